sent_rx_decoder: RTL and testbench
==================================

// Module: sent_rx_decoder
// PURPOSE
//  SENT receiver for one fast channel: samples sent_i, measures falling-edge-to-falling-edge intervals in ticks,
//  decodes sync/status/data/CRC nibbles, checks the 4-bit CRC and assembles the short serial message from status
//  bits 3:2. Sits between the SENT pin and the host data registers, mirror of the transmit control block.
// PARAMETERS
//  TICK_CLKS    8  clk_rx cycles per SENT tick (>=4, even)
//  NUM_NIBBLES  6  data nibbles per frame (1..6)
//  SYNC_TOL     3  accepted sync window = 56 +/- SYNC_TOL ticks
// PORTS
//  clk_rx            in   1                only clock
//  reset_rx          in   1                synchronous, active-high reset
//  sent_i            in   1                raw SENT line, asynchronous
//  enable_i          in   1                0: force HUNT, suppress all output pulses
//  optional_pause_i  in   1                1: one pause pulse allowed between CRC and next sync
//  data_o            out  4*NUM_NIBBLES    last good frame data, first nibble in MSBs
//  status_o          out  4                status nibble of last good frame
//  frame_valid_o     out  1                1-cycle pulse: frame received, CRC correct
//  crc_err_o         out  1                1-cycle pulse: frame CRC mismatch
//  frame_err_o       out  1                1-cycle pulse: interval out of range in STATUS/DATA/CRC/WAIT_SYNC
//  serial_id_o       out  4                short serial message ID
//  serial_data_o     out  8                short serial message data
//  serial_valid_o    out  1                1-cycle pulse: serial message complete, serial CRC correct
//  serial_crc_err_o  out  1                1-cycle pulse: serial CRC mismatch
// BEHAVIOUR
//  - Reset: every output 0, FSM=HUNT, tick/serial counters 0. Reset mid-frame discards the partial frame and serial message.
//  - Input: 2-FF synchronizer + registered previous sample; falling edge = prev & !sync. Output pulses appear
//    3 clk_rx cycles after the sent_i falling edge that closes the CRC nibble.
//  - Interval: sub-counter loads TICK_CLKS/2 at each edge; tick count = floor((L+TICK_CLKS/2)/TICK_CLKS), L = cycles
//    between edges; 10 bits, saturates at 1023.
//  - Classification: SYNC if |ticks-56|<=SYNC_TOL; NIBBLE if 12..27, value=ticks-12; PAUSE if 12..768 (WAIT_SYNC only).
//  - FSM: HUNT -SYNC-> STATUS -NIBBLE-> DATA(x NUM_NIBBLES) -NIBBLE-> CRC -edge-> WAIT_SYNC.
//    WAIT_SYNC: SYNC->STATUS; PAUSE with optional_pause_i=1 and no pause yet->stay (flag set); else frame_err_o, ->HUNT.
//    Non-NIBBLE interval in STATUS/DATA/CRC: frame_err_o, ->HUNT; partial frame dropped, outputs unchanged.
//    HUNT ignores non-sync intervals silently. enable_i=0: ->HUNT next cycle, no pulses.
//  - CRC4: table T={0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}; c=5; per data nibble c=T[c]^d; final c=T[c].
//    Status nibble excluded. Match: data_o/status_o updated, frame_valid_o. Mismatch: crc_err_o, data_o held.
//  - Serial (good frames only): status[3]=1 restarts collection at bit 0 from status[2]; status[3]=0 appends when
//    collecting, ignored otherwise. 16th bit: shift reg = {id[3:0], data[7:0], crc[3:0]}, MSB first; CRC4 over
//    id, data[7:4], data[3:0]. Match: serial_id_o/serial_data_o updated, serial_valid_o; else serial_crc_err_o.
//    Collection stops after 16 bits. crc_err_o/frame_err_o abort collection.
//  - Simultaneous frame_valid_o and serial_valid_o allowed, same cycle.
// TESTING (TICK_CLKS=8, NUM_NIBBLES=6)
//  - Reset: all outputs 0; sync 56t, status 0, data 0,0,0,0,0,0, CRC 5 -> frame_valid_o, data_o=24'h000000.
//  - Same frame, CRC nibble 4 -> crc_err_o=1, frame_valid_o=0, data_o unchanged.
//  - Data nibble of 30 ticks mid-frame -> frame_err_o; next valid frame decoded normally.
//  - optional_pause_i=1, pause 100t between frames -> both frames valid; 2nd pause -> frame_err_o.
//  - 16 frames carrying serial id=4'h3, data=8'hA5 + correct CRC, bit3=1 on frame 0 -> one serial_valid_o; bad CRC -> serial_crc_err_o.
//  - Sync of 60t and 50t (SYNC_TOL=3): 60t ignored in HUNT; reset_rx mid-frame -> no pulses from partial frame.

Source files
------------

// File: rtl/sent_rx_decoder.sv
// sent_rx_decoder: SENT fast-channel receiver with frame CRC check and short serial message assembly.
module sent_rx_decoder #(
  parameter int unsigned TICK_CLKS   = 8,
  parameter int unsigned NUM_NIBBLES = 6,
  parameter int unsigned SYNC_TOL    = 3
) (
  input  logic                     clk_rx,
  input  logic                     reset_rx,
  input  logic                     sent_i,
  input  logic                     enable_i,
  input  logic                     optional_pause_i,
  output logic [4*NUM_NIBBLES-1:0] data_o,
  output logic [3:0]               status_o,
  output logic                     frame_valid_o,
  output logic                     crc_err_o,
  output logic                     frame_err_o,
  output logic [3:0]               serial_id_o,
  output logic [7:0]               serial_data_o,
  output logic                     serial_valid_o,
  output logic                     serial_crc_err_o
);
  localparam int unsigned DW      = 4 * NUM_NIBBLES;
  localparam int unsigned SW      = $clog2(TICK_CLKS);
  localparam int unsigned SW1     = SW + 1;
  localparam int unsigned CW      = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
  localparam int unsigned TW      = 10;
  localparam int unsigned SYNC_LO = 56 - SYNC_TOL;
  localparam int unsigned SYNC_HI = 56 + SYNC_TOL;
  localparam logic [TW-1:0] TICK_MAX = '1;
  localparam logic [3:0]    CRC_SEED = 4'd5;

  typedef enum logic [2:0] {S_HUNT, S_STATUS, S_DATA, S_CRC, S_WAIT} state_t;

  // SENT CRC4 lookup table
  function automatic logic [3:0] crc_tab(input logic [3:0] c);
    logic [3:0] r;
    case (c)
      4'd0:  r = 4'd0;   4'd1:  r = 4'd13;  4'd2:  r = 4'd7;   4'd3:  r = 4'd10;
      4'd4:  r = 4'd14;  4'd5:  r = 4'd3;   4'd6:  r = 4'd9;   4'd7:  r = 4'd4;
      4'd8:  r = 4'd1;   4'd9:  r = 4'd12;  4'd10: r = 4'd6;   4'd11: r = 4'd11;
      4'd12: r = 4'd15;  4'd13: r = 4'd2;   4'd14: r = 4'd8;   default: r = 4'd5;
    endcase
    return r;
  endfunction

  // CRC4 over the three message nibbles of a short serial message
  function automatic logic [3:0] serial_crc(input logic [11:0] m);
    logic [3:0] c;
    c = CRC_SEED;
    c = crc_tab(c) ^ m[11:8];
    c = crc_tab(c) ^ m[7:4];
    c = crc_tab(c) ^ m[3:0];
    return crc_tab(c);
  endfunction

  logic           sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [SW-1:0]  sub_q, sub_d;
  logic [TW-1:0]  tick_q, tick_d, iv_q, iv_d;
  logic           ev_q, ev_d;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     crc_q, crc_d, stat_buf_q, stat_buf_d;
  logic [DW-1:0]  buf_q, buf_d, data_q, data_d;
  logic           pause_seen_q, pause_seen_d;
  logic [3:0]     status_q, status_d;
  logic           fv_q, fv_d, ce_q, ce_d, fe_q, fe_d;
  logic           ser_act_q, ser_act_d;
  logic [3:0]     ser_cnt_q, ser_cnt_d;
  logic [14:0]    ser_sr_q, ser_sr_d;
  logic [3:0]     sid_q, sid_d;
  logic [7:0]     sdata_q, sdata_d;
  logic           sv_q, sv_d, sce_q, sce_d;

  logic           fall, wrap;
  logic [SW1-1:0] sub_inc;
  logic [TW-1:0]  tick_inc, tick_now;
  logic           is_sync, is_nib, is_pause;
  logic [3:0]     nib_val;
  logic [15:0]    sr_new;

  // Input synchronizer, falling-edge detect and edge-to-edge tick measurement
  always_comb begin
    sync1_d  = sent_i;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    fall     = prev_q & ~sync2_q;
    sub_inc  = {1'b0, sub_q} + SW1'(1);
    wrap     = (sub_inc == SW1'(TICK_CLKS));
    tick_inc = (tick_q == TICK_MAX) ? tick_q : tick_q + TW'(1);
    tick_now = wrap ? tick_inc : tick_q;
    ev_d     = fall;
    iv_d     = iv_q;
    if (fall) begin
      sub_d  = SW'(TICK_CLKS / 2);
      tick_d = '0;
      iv_d   = tick_now;
    end else begin
      sub_d  = wrap ? '0 : sub_inc[SW-1:0];
      tick_d = tick_now;
    end
  end

  // Classify the last measured interval
  always_comb begin
    is_sync  = (iv_q >= TW'(SYNC_LO)) && (iv_q <= TW'(SYNC_HI));
    is_nib   = (iv_q >= TW'(12)) && (iv_q <= TW'(27));
    is_pause = (iv_q >= TW'(12)) && (iv_q <= TW'(768));
    nib_val  = 4'(iv_q - TW'(12));
  end

  // Frame FSM, frame CRC check and serial message assembly
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    crc_d        = crc_q;
    stat_buf_d   = stat_buf_q;
    buf_d        = buf_q;
    pause_seen_d = pause_seen_q;
    data_d       = data_q;
    status_d     = status_q;
    fv_d         = 1'b0;
    ce_d         = 1'b0;
    fe_d         = 1'b0;
    ser_act_d    = ser_act_q;
    ser_cnt_d    = ser_cnt_q;
    ser_sr_d     = ser_sr_q;
    sid_d        = sid_q;
    sdata_d      = sdata_q;
    sv_d         = 1'b0;
    sce_d        = 1'b0;
    sr_new       = {ser_sr_q, stat_buf_q[2]};
    if (!enable_i) begin
      state_d = S_HUNT;
    end else if (ev_q) begin
      unique case (state_q)
        S_HUNT: begin
          if (is_sync) begin
            state_d      = S_STATUS;
            pause_seen_d = 1'b0;
          end
        end
        S_STATUS: begin
          if (is_nib) begin
            stat_buf_d = nib_val;
            crc_d      = CRC_SEED;
            cnt_d      = '0;
            state_d    = S_DATA;
          end else begin
            fe_d      = 1'b1;
            ser_act_d = 1'b0;
            state_d   = S_HUNT;
          end
        end
        S_DATA: begin
          if (is_nib) begin
            buf_d = DW'({buf_q, nib_val});
            crc_d = crc_tab(crc_q) ^ nib_val;
            if (cnt_q == CW'(NUM_NIBBLES - 1)) state_d = S_CRC;
            else cnt_d = cnt_q + CW'(1);
          end else begin
            fe_d      = 1'b1;
            ser_act_d = 1'b0;
            state_d   = S_HUNT;
          end
        end
        S_CRC: begin
          if (is_nib) begin
            state_d      = S_WAIT;
            pause_seen_d = 1'b0;
            if (nib_val == crc_tab(crc_q)) begin
              data_d   = buf_q;
              status_d = stat_buf_q;
              fv_d     = 1'b1;
              if (stat_buf_q[3]) begin
                ser_sr_d  = 15'(stat_buf_q[2]);
                ser_cnt_d = 4'd1;
                ser_act_d = 1'b1;
              end else if (ser_act_q) begin
                ser_sr_d  = sr_new[14:0];
                ser_cnt_d = ser_cnt_q + 4'd1;
                if (ser_cnt_q == 4'd15) begin
                  ser_act_d = 1'b0;
                  ser_cnt_d = 4'd0;
                  if (sr_new[3:0] == serial_crc(sr_new[15:4])) begin
                    sid_d   = sr_new[15:12];
                    sdata_d = sr_new[11:4];
                    sv_d    = 1'b1;
                  end else begin
                    sce_d = 1'b1;
                  end
                end
              end
            end else begin
              ce_d      = 1'b1;
              ser_act_d = 1'b0;
            end
          end else begin
            fe_d      = 1'b1;
            ser_act_d = 1'b0;
            state_d   = S_HUNT;
          end
        end
        S_WAIT: begin
          if (is_sync) begin
            state_d      = S_STATUS;
            pause_seen_d = 1'b0;
          end else if (is_pause && optional_pause_i && !pause_seen_q) begin
            pause_seen_d = 1'b1;
          end else begin
            fe_d      = 1'b1;
            ser_act_d = 1'b0;
            state_d   = S_HUNT;
          end
        end
        default: state_d = S_HUNT;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      sync1_q <= 1'b0;  sync2_q <= 1'b0;  prev_q <= 1'b0;
      sub_q <= '0;  tick_q <= '0;  iv_q <= '0;  ev_q <= 1'b0;
      state_q <= S_HUNT;  cnt_q <= '0;  crc_q <= '0;  stat_buf_q <= '0;
      buf_q <= '0;  pause_seen_q <= 1'b0;  data_q <= '0;  status_q <= '0;
      fv_q <= 1'b0;  ce_q <= 1'b0;  fe_q <= 1'b0;
      ser_act_q <= 1'b0;  ser_cnt_q <= '0;  ser_sr_q <= '0;
      sid_q <= '0;  sdata_q <= '0;  sv_q <= 1'b0;  sce_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;  sync2_q <= sync2_d;  prev_q <= prev_d;
      sub_q <= sub_d;  tick_q <= tick_d;  iv_q <= iv_d;  ev_q <= ev_d;
      state_q <= state_d;  cnt_q <= cnt_d;  crc_q <= crc_d;  stat_buf_q <= stat_buf_d;
      buf_q <= buf_d;  pause_seen_q <= pause_seen_d;  data_q <= data_d;  status_q <= status_d;
      fv_q <= fv_d;  ce_q <= ce_d;  fe_q <= fe_d;
      ser_act_q <= ser_act_d;  ser_cnt_q <= ser_cnt_d;  ser_sr_q <= ser_sr_d;
      sid_q <= sid_d;  sdata_q <= sdata_d;  sv_q <= sv_d;  sce_q <= sce_d;
    end
  end

  assign data_o           = data_q;
  assign status_o         = status_q;
  assign frame_valid_o    = fv_q;
  assign crc_err_o        = ce_q;
  assign frame_err_o      = fe_q;
  assign serial_id_o      = sid_q;
  assign serial_data_o    = sdata_q;
  assign serial_valid_o   = sv_q;
  assign serial_crc_err_o = sce_q;
endmodule

// File: tb/tb_sent_rx_decoder.sv
// tb_sent_rx_decoder: directed SENT frames with a scoreboard of expected receiver output pulses.
module tb_sent_rx_decoder;
  localparam int unsigned T = 8;

  logic        clk_rx = 1'b0;
  logic        reset_rx, sent_i, enable_i, optional_pause_i;
  logic [23:0] data_o;
  logic [3:0]  status_o, serial_id_o;
  logic [7:0]  serial_data_o;
  logic        frame_valid_o, crc_err_o, frame_err_o, serial_valid_o, serial_crc_err_o;

  sent_rx_decoder #(.TICK_CLKS(8), .NUM_NIBBLES(6), .SYNC_TOL(3)) dut (
    .clk_rx(clk_rx), .reset_rx(reset_rx), .sent_i(sent_i), .enable_i(enable_i),
    .optional_pause_i(optional_pause_i), .data_o(data_o), .status_o(status_o),
    .frame_valid_o(frame_valid_o), .crc_err_o(crc_err_o), .frame_err_o(frame_err_o),
    .serial_id_o(serial_id_o), .serial_data_o(serial_data_o),
    .serial_valid_o(serial_valid_o), .serial_crc_err_o(serial_crc_err_o)
  );

  always #5 clk_rx = ~clk_rx;

  typedef struct packed {
    logic        fv, ce, fe, sv, sce;
    logic [23:0] data;
    logic [3:0]  status;
    logic [3:0]  sid;
    logic [7:0]  sdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          fails  = 0;
  logic [23:0] exp_data   = '0;
  logic [3:0]  exp_status = '0;
  logic [3:0]  exp_sid    = '0;
  logic [7:0]  exp_sdata  = '0;
  logic [15:0] sbits;
  logic [3:0]  st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic fv, input logic ce, input logic fe, input logic sv, input logic sce);
    exp_t e;
    e.fv = fv; e.ce = ce; e.fe = fe; e.sv = sv; e.sce = sce;
    e.data = exp_data; e.status = exp_status; e.sid = exp_sid; e.sdata = exp_sdata;
    exp_q.push_back(e);
  endtask

  // One SENT interval: 4 ticks low, then high for the remainder
  task automatic send_interval(input int ticks);
    sent_i = 1'b0;
    repeat (4 * T) @(negedge clk_rx);
    sent_i = 1'b1;
    repeat ((ticks - 4) * T) @(negedge clk_rx);
  endtask

  task automatic send_frame(input int sync_t, input logic [3:0] s, input logic [23:0] d, input logic [3:0] crc);
    send_interval(sync_t);
    send_interval(12 + int'(s));
    for (int i = 0; i < 6; i++) send_interval(12 + int'(d[23-4*i -: 4]));
    send_interval(12 + int'(crc));
  endtask

  task automatic good_frame(input int sync_t, input logic [3:0] s, input logic [23:0] d, input logic [3:0] crc);
    send_frame(sync_t, s, d, crc);
    exp_data = d;
    exp_status = s;
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_data"}, 32'(data_o), 32'(exp_data));
    chk({tag, "_status"}, 32'(status_o), 32'(exp_status));
    chk({tag, "_sid"}, 32'(serial_id_o), 32'(exp_sid));
    chk({tag, "_sdata"}, 32'(serial_data_o), 32'(exp_sdata));
    chk({tag, "_pulses"}, 32'({frame_valid_o, crc_err_o, frame_err_o, serial_valid_o, serial_crc_err_o}), 32'(0));
  endtask

  // Monitor: every output pulse must match the oldest expected event
  always @(negedge clk_rx) begin
    if (frame_valid_o | crc_err_o | frame_err_o | serial_valid_o | serial_crc_err_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pulse: got fv=%0b ce=%0b fe=%0b sv=%0b sce=%0b, expected none at %0t",
                 frame_valid_o, crc_err_o, frame_err_o, serial_valid_o, serial_crc_err_o, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("frame_valid", 32'(frame_valid_o), 32'(mon_e.fv));
        chk("crc_err", 32'(crc_err_o), 32'(mon_e.ce));
        chk("frame_err", 32'(frame_err_o), 32'(mon_e.fe));
        chk("serial_valid", 32'(serial_valid_o), 32'(mon_e.sv));
        chk("serial_crc_err", 32'(serial_crc_err_o), 32'(mon_e.sce));
        chk("data", 32'(data_o), 32'(mon_e.data));
        chk("status", 32'(status_o), 32'(mon_e.status));
        chk("serial_id", 32'(serial_id_o), 32'(mon_e.sid));
        chk("serial_data", 32'(serial_data_o), 32'(mon_e.sdata));
      end
    end
  end

  initial begin
    sent_i = 1'b1; reset_rx = 1'b1; enable_i = 1'b1; optional_pause_i = 1'b0;
    repeat (3) @(negedge clk_rx);
    reset_rx = 1'b0;
    @(negedge clk_rx);
    check_idle_outputs("reset");
    repeat (20) @(negedge clk_rx);

    // Basic frames, CRC error, second data pattern
    good_frame(56, 4'h0, 24'h000000, 4'h5);
    send_frame(56, 4'h0, 24'h000000, 4'h4);
    push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    good_frame(56, 4'h1, 24'h123456, 4'h2);

    // Out-of-range data nibble (30 ticks) mid-frame
    send_interval(56);
    send_interval(13);
    send_interval(15);
    send_interval(30);
    push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    good_frame(56, 4'h2, 24'h70F189, 4'h7);

    // Optional pause: one allowed, a second one is an error
    optional_pause_i = 1'b1;
    good_frame(56, 4'h0, 24'h000000, 4'h5);
    send_interval(100);
    good_frame(56, 4'h3, 24'h70F189, 4'h7);
    send_interval(100);
    send_interval(100);
    push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    good_frame(56, 4'h0, 24'h000000, 4'h5);
    optional_pause_i = 1'b0;

    // Reset in the middle of a frame
    send_interval(56);
    send_interval(12);
    send_interval(13);
    sent_i = 1'b0;
    repeat (4 * T) @(negedge clk_rx);
    sent_i = 1'b1;
    repeat (20) @(negedge clk_rx);
    chk("pending_before_reset", 32'(exp_q.size()), 32'(0));
    reset_rx = 1'b1;
    repeat (2) @(negedge clk_rx);
    reset_rx = 1'b0;
    exp_data = '0; exp_status = '0; exp_sid = '0; exp_sdata = '0;
    @(negedge clk_rx);
    check_idle_outputs("midreset");
    repeat (10) @(negedge clk_rx);

    // Sync tolerance: 60 and 50 ignored in HUNT, 53 and 59 accepted
    send_interval(60);
    send_interval(50);
    good_frame(53, 4'h0, 24'h000000, 4'h5);
    good_frame(59, 4'h6, 24'h123456, 4'h2);

    // Short serial message id=3 data=A5 crc=A, then same with a bad serial CRC
    for (int pass = 0; pass < 2; pass++) begin
      sbits = (pass == 0) ? 16'h3A5A : 16'h3A50;
      for (int k = 0; k < 16; k++) begin
        st = {(k == 0), sbits[15-k], 2'b00};
        send_frame(56, st, 24'h000000, 4'h5);
        exp_data = 24'h000000;
        exp_status = st;
        if (k == 15 && pass == 0) begin
          exp_sid = 4'h3;
          exp_sdata = 8'hA5;
          push(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end else if (k == 15) begin
          push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        end else begin
          push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
      end
    end

    // Closing edge for the last CRC nibble
    sent_i = 1'b0;
    repeat (4 * T) @(negedge clk_rx);
    sent_i = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk_rx);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    repeat (20) @(negedge clk_rx);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
